// File: rtl/noc_buffer_pkg.sv
// Shared NoC buffer defaults, flit type and the clog2 helper used to size
// pointers, counters and VC indices.
package noc_buffer_pkg;

  localparam int unsigned DefaultFlitSize   = 16;
  localparam int unsigned DefaultBufferSize = 8;
  localparam int unsigned DefaultVcNum      = 2;

  typedef logic [DefaultFlitSize-1:0] flit_t;

  // Smallest n with 2**n >= value; clog2(1) == 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Single-VC circular flit FIFO with registered empty/full flags and
// first-word fall-through head output. The caller only asserts accepted ops.
module flit_fifo #(
  parameter int unsigned FLIT_SIZE   = 16,
  parameter int unsigned BUFFER_SIZE = 8,
  parameter int unsigned PTR_W       = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [CNT_W-1:0]     cnt,
  output logic                 empty,
  output logic                 full
);

  logic [FLIT_SIZE-1:0] mem [BUFFER_SIZE];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, full_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(BUFFER_SIZE - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_en ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = wr_en ? next_ptr(wr_ptr_q) : wr_ptr_q;
    cnt_d    = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Flags are derived from the next count so they track cnt every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == CNT_W'(BUFFER_SIZE));
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= data_i;
  end

  assign data_o = mem[rd_ptr_q];
  assign cnt    = cnt_q;
  assign empty  = empty_q;
  assign full   = full_q;

endmodule

// File: rtl/vc_flit_buffer.sv
// Input-port VC buffer: per-VC FIFOs, acceptance logic, head-flit mux,
// registered credit return and a sticky protocol-error flag.
module vc_flit_buffer
  import noc_buffer_pkg::*;
#(
  parameter int unsigned FLIT_SIZE   = DefaultFlitSize,
  parameter int unsigned BUFFER_SIZE = DefaultBufferSize,
  parameter int unsigned VC_NUM      = DefaultVcNum,
  localparam int unsigned VC_W  = (clog2(VC_NUM) > 1) ? clog2(VC_NUM) : 1,
  localparam int unsigned PTR_W = (clog2(BUFFER_SIZE) > 1) ? clog2(BUFFER_SIZE) : 1,
  localparam int unsigned CNT_W = clog2(BUFFER_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] data_i,
  input  logic                 write_i,
  input  logic [VC_W-1:0]      vc_wr_i,
  input  logic                 read_i,
  input  logic [VC_W-1:0]      vc_rd_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic [VC_NUM-1:0]    empty_o,
  output logic [VC_NUM-1:0]    full_o,
  output logic                 credit_o,
  output logic [VC_W-1:0]      credit_vc_o,
  output logic                 error_o
);

  logic [VC_NUM-1:0]    wr_en, rd_en, fifo_empty, fifo_full;
  logic [FLIT_SIZE-1:0] fifo_data [VC_NUM];
  logic [CNT_W-1:0]     fifo_cnt  [VC_NUM];

  logic                 wr_in_range, rd_in_range;
  logic                 wr_full_sel, rd_empty_sel;
  logic [FLIT_SIZE-1:0] head;
  logic                 ra, wa;

  logic                 credit_q, credit_d;
  logic [VC_W-1:0]      credit_vc_q, credit_vc_d;
  logic                 error_q, error_d;

  // With a power-of-two VC count every index encodes a real VC.
  if (VC_NUM == (1 << VC_W)) begin : g_range_full
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_range_check
    assign wr_in_range = (32'(vc_wr_i) < VC_NUM);
    assign rd_in_range = (32'(vc_rd_i) < VC_NUM);
  end

  always_comb begin
    head         = '0;
    rd_empty_sel = 1'b1;
    wr_full_sel  = 1'b0;
    for (int v = 0; v < int'(VC_NUM); v++) begin
      if (vc_rd_i == VC_W'(v)) begin
        head         = fifo_data[v];
        rd_empty_sel = fifo_empty[v];
      end
      if (vc_wr_i == VC_W'(v)) wr_full_sel = fifo_full[v];
    end
  end

  // A full VC still takes a write when the same cycle frees a slot in it.
  always_comb begin
    ra = read_i & rd_in_range & ~rd_empty_sel;
    wa = write_i & wr_in_range & (~wr_full_sel | (ra & (vc_rd_i == vc_wr_i)));
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    assign wr_en[v] = wa & (vc_wr_i == VC_W'(v));
    assign rd_en[v] = ra & (vc_rd_i == VC_W'(v));

    flit_fifo #(
      .FLIT_SIZE  (FLIT_SIZE),
      .BUFFER_SIZE(BUFFER_SIZE),
      .PTR_W      (PTR_W),
      .CNT_W      (CNT_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr_en (wr_en[v]),
      .rd_en (rd_en[v]),
      .data_i(data_i),
      .data_o(fifo_data[v]),
      .cnt   (fifo_cnt[v]),
      .empty (fifo_empty[v]),
      .full  (fifo_full[v])
    );

    flags_track_cnt: assert property (@(posedge clk) disable iff (rst)
      (fifo_empty[v] == (fifo_cnt[v] == '0)) &&
      (fifo_full[v] == (fifo_cnt[v] == CNT_W'(BUFFER_SIZE))));
  end

  always_comb begin
    credit_d    = ra;
    credit_vc_d = vc_rd_i;
    error_d     = error_q | (write_i & ~wa) | (read_i & ~ra);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q    <= 1'b0;
      credit_vc_q <= '0;
      error_q     <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      credit_vc_q <= credit_vc_d;
      error_q     <= error_d;
    end
  end

  assign data_o      = head;
  assign empty_o     = fifo_empty;
  assign full_o      = fifo_full;
  assign credit_o    = credit_q;
  assign credit_vc_o = credit_vc_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_vc_flit_buffer.sv
// Directed plus randomized bench for vc_flit_buffer against a per-VC queue model.
module tb_vc_flit_buffer;

  localparam int FS = 16;
  localparam int BS = 8;
  localparam int VN = 2;
  localparam int VW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FS-1:0] data_i = '0;
  logic          write_i = 1'b0;
  logic [VW-1:0] vc_wr_i = '0;
  logic          read_i = 1'b0;
  logic [VW-1:0] vc_rd_i = '0;
  logic [FS-1:0] data_o;
  logic [VN-1:0] empty_o, full_o;
  logic          credit_o;
  logic [VW-1:0] credit_vc_o;
  logic          error_o;

  vc_flit_buffer #(
    .FLIT_SIZE  (FS),
    .BUFFER_SIZE(BS),
    .VC_NUM     (VN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .write_i    (write_i),
    .vc_wr_i    (vc_wr_i),
    .read_i     (read_i),
    .vc_rd_i    (vc_rd_i),
    .data_o     (data_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .credit_o   (credit_o),
    .credit_vc_o(credit_vc_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: one FIFO queue per VC plus expected registered outputs.
  logic [FS-1:0] q [VN][$];
  logic          m_err = 1'b0;
  logic          m_credit = 1'b0;
  logic [VW-1:0] m_cvc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic post_checks();
    logic [VN-1:0] m_empty, m_full;
    for (int v = 0; v < VN; v++) begin
      m_empty[v] = (q[v].size() == 0);
      m_full[v]  = (q[v].size() == BS);
    end
    chk("empty_o", 32'(empty_o), 32'(m_empty));
    chk("full_o", 32'(full_o), 32'(m_full));
    chk("credit_o", 32'(credit_o), 32'(m_credit));
    chk("credit_vc_o", 32'(credit_vc_o), 32'(m_cvc));
    chk("error_o", 32'(error_o), 32'(m_err));
  endtask

  // Drive one cycle from a negedge; head flit is checked before the edge.
  task automatic cycle(input logic w, input logic [VW-1:0] vw, input logic [FS-1:0] d,
                       input logic r, input logic [VW-1:0] vr);
    bit ra, wa;
    write_i = w;
    vc_wr_i = vw;
    data_i  = d;
    read_i  = r;
    vc_rd_i = vr;
    #1;
    if (q[vr].size() > 0) chk("data_o", 32'(data_o), 32'(q[vr][0]));
    ra = r && (int'(vr) < VN) && (q[vr].size() > 0);
    wa = w && (int'(vw) < VN) && ((q[vw].size() < BS) || (ra && vr == vw));
    @(posedge clk);
    if (ra) void'(q[vr].pop_front());
    if (wa) q[vw].push_back(d);
    m_err    = m_err | (w && !wa) | (r && !ra);
    m_credit = ra;
    m_cvc    = vr;
    @(negedge clk);
    post_checks();
  endtask

  task automatic do_reset(input logic r);
    rst     = 1'b1;
    read_i  = r;
    vc_rd_i = '0;
    write_i = 1'($urandom_range(0, 1));
    vc_wr_i = '0;
    data_i  = 16'($urandom);
    @(posedge clk);
    for (int v = 0; v < VN; v++) q[v].delete();
    m_err    = 1'b0;
    m_credit = 1'b0;
    m_cvc    = '0;
    @(negedge clk);
    rst     = 1'b0;
    write_i = 1'b0;
    read_i  = 1'b0;
    post_checks();
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

    // Fill VC0 past capacity, then drain in order.
    for (int i = 1; i <= 9; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Full VC1 under sustained read+write across pointer wrap.
    repeat (8) cycle(1'b1, 1'b1, 16'($urandom), 1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b1, 16'($urandom), 1'b1, 1'b1);

    // Write one VC while reading another.
    do_reset(1'b0);
    cycle(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b1);

    // Read of empty VC0 alongside a write to it.
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // Reset while VC0 holds flits and a read is requested.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
    do_reset(1'b1);

    // Randomized traffic with phase-dependent write bias.
    for (int i = 0; i < 1500; i++) begin
      int wbias;
      wbias = ((i / 100) % 2 == 0) ? 75 : 35;
      if ($urandom_range(0, 299) == 0) do_reset(1'($urandom_range(0, 1)));
      else cycle(($urandom_range(0, 99) < wbias), 1'($urandom), 16'($urandom),
                 ($urandom_range(0, 99) < 55), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
